// File: rtl/dram_arbiter_rr.sv
// Round-robin arbiter sharing one DRAM controller among NUM_PORTS masters.
// Define ARB_TIMEOUT_EN to build in the BUSY-state watchdog (limit TIMEOUT_CYCLES).
module dram_arbiter_rr #(
  parameter int NUM_PORTS      = 4,
  parameter int ADDR_WIDTH     = 24,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_PORTS-1:0]             req_read,
  input  logic [NUM_PORTS-1:0]             req_write,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  addr,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]  data_in,
  output logic [DATA_WIDTH-1:0]            data_out,
  output logic [NUM_PORTS-1:0]             data_valid,
  output logic [NUM_PORTS-1:0]             write_complete,
  output logic [NUM_PORTS-1:0]             timeout_err,
  output logic [ADDR_WIDTH-1:0]            dram_addr,
  output logic [DATA_WIDTH-1:0]            dram_data_in,
  output logic                             dram_req_read,
  output logic                             dram_req_write,
  input  logic [DATA_WIDTH-1:0]            dram_data_out,
  input  logic                             dram_data_out_valid,
  input  logic                             dram_write_complete
);

  localparam int PW = $clog2(NUM_PORTS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                  state_r, state_next_s;
  logic [PW-1:0]           last_grant_r, grant_r, grant_idx_s, cand_s;
  logic [NUM_PORTS-1:0]    pending_s, grant_onehot_s;
  logic                    any_pending_s, wr_sel_s, op_write_r;
  logic                    complete_s, abort_s;
  logic [ADDR_WIDTH-1:0]   addr_sel_s, dram_addr_r;
  logic [DATA_WIDTH-1:0]   data_sel_s, dram_data_in_r, data_out_r;
  logic [NUM_PORTS-1:0]    data_valid_r, write_complete_r;
  logic                    dram_req_read_r, dram_req_write_r;

  assign grant_onehot_s = NUM_PORTS'(1'b1) << grant_r;
  // Only a strobe matching the op in flight counts; strays in other states are dropped.
  assign complete_s     = (state_r == BUSY) &&
                          (op_write_r ? dram_write_complete : dram_data_out_valid);

  // Round-robin pick: scan from the lowest priority down so the nearest port after last_grant wins.
  always_comb begin
    pending_s     = req_read | req_write;
    any_pending_s = |pending_s;
    grant_idx_s   = '0;
    cand_s        = '0;
    for (int k = NUM_PORTS; k >= 1; k--) begin
      cand_s      = PW'((int'(last_grant_r) + k) % NUM_PORTS);
      grant_idx_s = pending_s[cand_s] ? cand_s : grant_idx_s;
    end
    addr_sel_s = '0;
    data_sel_s = '0;
    wr_sel_s   = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      addr_sel_s = (grant_idx_s == PW'(i)) ? addr[i*ADDR_WIDTH +: ADDR_WIDTH]    : addr_sel_s;
      data_sel_s = (grant_idx_s == PW'(i)) ? data_in[i*DATA_WIDTH +: DATA_WIDTH] : data_sel_s;
      wr_sel_s   = (grant_idx_s == PW'(i)) ? req_write[i]                         : wr_sel_s;
    end
  end

  // Next-state decode.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE:    state_next_s = any_pending_s ? BUSY : IDLE;
      BUSY:    state_next_s = (complete_s || abort_s) ? DONE : BUSY;
      DONE:    state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Grant capture, DRAM request handshake and completion pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_r     <= PW'(NUM_PORTS - 1);
      grant_r          <= '0;
      op_write_r       <= 1'b0;
      dram_addr_r      <= '0;
      dram_data_in_r   <= '0;
      dram_req_read_r  <= 1'b0;
      dram_req_write_r <= 1'b0;
      data_out_r       <= '0;
      data_valid_r     <= '0;
      write_complete_r <= '0;
    end else begin
      data_valid_r     <= '0;
      write_complete_r <= '0;
      case (state_r)
        IDLE: begin
          if (any_pending_s) begin
            // A simultaneous read+write on one port is served as the write.
            grant_r          <= grant_idx_s;
            op_write_r       <= wr_sel_s;
            dram_addr_r      <= addr_sel_s;
            dram_data_in_r   <= data_sel_s;
            dram_req_read_r  <= ~wr_sel_s;
            dram_req_write_r <= wr_sel_s;
          end
        end
        BUSY: begin
          if (complete_s) begin
            dram_req_read_r  <= 1'b0;
            dram_req_write_r <= 1'b0;
            if (op_write_r) begin
              write_complete_r <= grant_onehot_s;
            end else begin
              data_valid_r <= grant_onehot_s;
              data_out_r   <= dram_data_out;
            end
          end else if (abort_s) begin
            dram_req_read_r  <= 1'b0;
            dram_req_write_r <= 1'b0;
          end
        end
        DONE: begin
          last_grant_r <= grant_r;
        end
        default: begin
          last_grant_r <= last_grant_r;
        end
      endcase
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WD_W-1:0]      wd_cnt_r;
  logic [NUM_PORTS-1:0] timeout_err_r;

  // Fires on the TIMEOUT_CYCLES-th BUSY cycle; a completion in that same cycle still wins.
  assign abort_s = (state_r == BUSY) && (wd_cnt_r == WD_W'(TIMEOUT_CYCLES - 1));

  // Watchdog counter and abort pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      wd_cnt_r      <= '0;
      timeout_err_r <= '0;
    end else begin
      wd_cnt_r      <= (state_r == BUSY) ? wd_cnt_r + WD_W'(1) : '0;
      timeout_err_r <= (abort_s && !complete_s) ? grant_onehot_s : '0;
    end
  end

  assign timeout_err = timeout_err_r;
`else
  assign abort_s     = 1'b0;
  // Without the watchdog TIMEOUT_CYCLES has no effect and the abort flags stay low.
  assign timeout_err = {NUM_PORTS{1'b0}} & {NUM_PORTS{(TIMEOUT_CYCLES > 0)}};
`endif

  assign data_out       = data_out_r;
  assign data_valid     = data_valid_r;
  assign write_complete = write_complete_r;
  assign dram_addr      = dram_addr_r;
  assign dram_data_in   = dram_data_in_r;
  assign dram_req_read  = dram_req_read_r;
  assign dram_req_write = dram_req_write_r;

endmodule

// File: tb/tb_dram_arbiter_rr.sv
// Directed, scoreboard-driven bench for dram_arbiter_rr (4 ports, TIMEOUT_CYCLES = 8).
// The watchdog scenario is built only when ARB_TIMEOUT_EN is defined.
module tb_dram_arbiter_rr;
  localparam int NP = 4;
  localparam int AW = 24;
  localparam int DW = 32;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NP-1:0]     req_read, req_write;
  logic [NP*AW-1:0]  addr;
  logic [NP*DW-1:0]  data_in;
  logic [DW-1:0]     data_out;
  logic [NP-1:0]     data_valid, write_complete, timeout_err;
  logic [AW-1:0]     dram_addr;
  logic [DW-1:0]     dram_data_in, dram_data_out;
  logic              dram_req_read, dram_req_write;
  logic              dram_data_out_valid, dram_write_complete;

  always #5 clk = ~clk;

  dram_arbiter_rr #(
    .NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk), .rst(rst),
    .req_read(req_read), .req_write(req_write), .addr(addr), .data_in(data_in),
    .data_out(data_out), .data_valid(data_valid), .write_complete(write_complete),
    .timeout_err(timeout_err), .dram_addr(dram_addr), .dram_data_in(dram_data_in),
    .dram_req_read(dram_req_read), .dram_req_write(dram_req_write),
    .dram_data_out(dram_data_out), .dram_data_out_valid(dram_data_out_valid),
    .dram_write_complete(dram_write_complete)
  );

  typedef struct {
    int          port;
    bit          wr;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } exp_t;

  exp_t          sb_q[$];
  int            n_assert = 0;
  int            n_fail   = 0;
  logic [DW-1:0] last_rd  = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic set_port(input int p, input bit rd, input bit wr,
                          input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_read[p]          = rd;
    req_write[p]         = wr;
    addr[p*AW +: AW]     = a;
    data_in[p*DW +: DW]  = d;
  endtask

  task automatic push(input int p, input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    exp_t e;
    e.port = p; e.wr = wr; e.a = a; e.d = d;
    sb_q.push_back(e);
  endtask

  // Controller model: answers the front scoreboard entry after lat request cycles.
  task automatic serve(input int lat, input bit stray, input logic [NP-1:0] drop_mask);
    exp_t e;
    int   n;
    bit   seen;
    if (sb_q.size() == 0) begin
      n_assert++;
      n_fail++;
      $error("FAIL sb_underflow: observed empty queue expected an entry");
      return;
    end
    e = sb_q[0];
    n = 0;
    while (!(dram_req_read || dram_req_write) && n < 20) begin
      tick();
      n++;
    end
    seen = dram_req_read || dram_req_write;
    chk("req_seen", seen, 1);
    if (!seen) begin
      e = sb_q.pop_front();
      return;
    end
    chk("req_latency", n, 1);
    chk("dram_req_write", dram_req_write, e.wr);
    chk("dram_req_read", dram_req_read, !e.wr);
    chk("grant_addr", dram_addr, e.a);
    if (e.wr) chk("dram_wdata", dram_data_in, e.d);
    for (int c = 1; c < lat; c++) begin
      if (stray && c == 1) begin
        if (e.wr) begin
          dram_data_out_valid = 1'b1;
          dram_data_out       = 32'hBAD0_BAD0;
        end else begin
          dram_write_complete = 1'b1;
        end
      end
      tick();
      dram_data_out_valid = 1'b0;
      dram_write_complete = 1'b0;
      chk("still_busy", dram_req_read || dram_req_write, 1);
      chk("no_early_pulse", data_valid | write_complete, 0);
    end
    if (e.wr) begin
      dram_write_complete = 1'b1;
    end else begin
      dram_data_out_valid = 1'b1;
      dram_data_out       = e.d;
    end
    tick();
    dram_write_complete = 1'b0;
    dram_data_out_valid = 1'b0;
    dram_data_out       = '0;
    e = sb_q.pop_front();
    chk("data_valid", data_valid, e.wr ? 0 : (1 << e.port));
    chk("write_complete", write_complete, e.wr ? (1 << e.port) : 0);
    if (!e.wr) last_rd = e.d;
    chk("data_out", data_out, last_rd);
    chk("req_dropped", dram_req_read || dram_req_write, 0);
    tick();
    req_read  = req_read & ~drop_mask;
    req_write = req_write & ~drop_mask;
    chk("pulse_one_cycle", data_valid | write_complete, 0);
    chk("no_req_after_done", dram_req_read || dram_req_write, 0);
  endtask

  // Per-cycle invariants.
  always @(negedge clk) begin
    if (!rst) begin
      chk("one_dram_req", dram_req_read & dram_req_write, 0);
`ifndef ARB_TIMEOUT_EN
      chk("timeout_tied_low", timeout_err, 0);
`endif
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    req_read = '0; req_write = '0; addr = '0; data_in = '0;
    dram_data_out = '0; dram_data_out_valid = 1'b0; dram_write_complete = 1'b0;
    rst = 1'b1;
    repeat (3) tick();
    chk("rst_req_read", dram_req_read, 0);
    chk("rst_req_write", dram_req_write, 0);
    chk("rst_data_valid", data_valid, 0);
    chk("rst_write_complete", write_complete, 0);
    chk("rst_timeout_err", timeout_err, 0);
    chk("rst_data_out", data_out, 0);
    chk("rst_dram_addr", dram_addr, 0);
    chk("rst_dram_data_in", dram_data_in, 0);

    // Port 2 read of 0x000010, controller answers 0xDEADBEEF after 5 cycles.
    rst = 1'b0;
    set_port(2, 1'b1, 1'b0, 24'h000010, 32'h0);
    push(2, 1'b0, 24'h000010, 32'hDEAD_BEEF);
    serve(5, 1'b1, 4'b0100);

    // All ports read together and stay held: order 0,1,2,3,0 from reset.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    last_rd = '0;
    for (int p = 0; p < NP; p++) set_port(p, 1'b1, 1'b0, 24'h000200 + AW'(p), 32'h0);
    for (int k = 0; k < 5; k++) push(k % NP, 1'b0, 24'h000200 + AW'(k % NP), 32'hA5A5_0000 | DW'(k));
    for (int k = 0; k < 4; k++) serve(2 + k, 1'b0, 4'b0000);
    serve(3, 1'b0, 4'b1111);

    // Port 1 read+write together: write wins, data_out untouched.
    set_port(1, 1'b1, 1'b1, 24'h000100, 32'h1234_5678);
    push(1, 1'b1, 24'h000100, 32'h1234_5678);
    serve(4, 1'b1, 4'b0010);

    // Strobes arriving in IDLE are ignored.
    dram_data_out_valid = 1'b1;
    dram_write_complete = 1'b1;
    dram_data_out       = 32'h5555_AAAA;
    tick();
    dram_data_out_valid = 1'b0;
    dram_write_complete = 1'b0;
    dram_data_out       = '0;
    tick();
    chk("idle_stray_pulse", data_valid | write_complete, 0);
    chk("idle_stray_data", data_out, last_rd);
    chk("idle_no_req", dram_req_read || dram_req_write, 0);

    // Reset while port 3 is BUSY, then port 0 takes the next grant.
    set_port(3, 1'b1, 1'b0, 24'h000300, 32'h0);
    n = 0;
    while (!dram_req_read && n < 20) begin
      tick();
      n++;
    end
    chk("p3_req", dram_req_read, 1);
    chk("p3_addr", dram_addr, 24'h000300);
    tick();
    rst = 1'b1;
    tick();
    chk("rst_busy_req", dram_req_read, 0);
    chk("rst_busy_valid", data_valid, 0);
    chk("rst_busy_data", data_out, 0);
    last_rd = '0;
    rst = 1'b0;
    set_port(0, 1'b1, 1'b0, 24'h000400, 32'h0);
    push(0, 1'b0, 24'h000400, 32'h0BAD_F00D);
    push(3, 1'b0, 24'h000300, 32'h3333_0003);
    serve(3, 1'b0, 4'b0001);
    serve(2, 1'b0, 4'b1000);

`ifdef ARB_TIMEOUT_EN
    // Controller silent: request lasts 8 cycles, timeout_err pulses, port 2 served next.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    last_rd = '0;
    set_port(1, 1'b1, 1'b0, 24'h000500, 32'h0);
    set_port(2, 1'b1, 1'b0, 24'h000600, 32'h0);
    n = 0;
    while (!dram_req_read && n < 20) begin
      tick();
      n++;
    end
    chk("to_req", dram_req_read, 1);
    chk("to_addr", dram_addr, 24'h000500);
    n = 0;
    while (dram_req_read && n < 50) begin
      n++;
      tick();
    end
    chk("to_busy_len", n, 8);
    chk("to_err_pulse", timeout_err, 4'b0010);
    chk("to_no_valid", data_valid, 0);
    tick();
    req_read[1] = 1'b0;
    chk("to_err_one_cycle", timeout_err, 0);
    chk("to_data_out", data_out, 0);
    push(2, 1'b0, 24'h000600, 32'h6666_0002);
    serve(3, 1'b0, 4'b0100);
`endif

    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/dram_arbiter_rr.md
DRAM_ARBITER_RR -- requirements
Module: dram_arbiter_rr

Interface
REQ-001 Parameter NUM_PORTS, default 4: number of requesting masters; legal range 2..8.
REQ-002 Parameter ADDR_WIDTH, default 24: word address width.
REQ-003 Parameter DATA_WIDTH, default 32: data word width.
REQ-004 Parameter TIMEOUT_CYCLES, default 1024: watchdog limit; only used when ARB_TIMEOUT_EN is defined.
REQ-005 The clock and reset SHALL be one clock and a synchronous, active-high reset, named as follows:
- clk  in  1  sole clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
REQ-006 The master-side ports SHALL be:
- req_read  in  NUM_PORTS  per-port read request; level, held until completion.
- req_write  in  NUM_PORTS  per-port write request; level, held until completion.
- addr  in  NUM_PORTS*ADDR_WIDTH  flattened addresses; port i at slice [i*ADDR_WIDTH +: ADDR_WIDTH].
- data_in  in  NUM_PORTS*DATA_WIDTH  flattened write data; sliced the same way as addr.
- data_out  out  DATA_WIDTH  last read data; shared by all ports.
- data_valid  out  NUM_PORTS  one-cycle read-complete pulse to the granted port.
- write_complete  out  NUM_PORTS  one-cycle write-complete pulse to the granted port.
- timeout_err  out  NUM_PORTS  one-cycle watchdog-abort pulse.
REQ-007 The DRAM-side ports SHALL be:
- dram_addr  out  ADDR_WIDTH  address to the controller.
- dram_data_in  out  DATA_WIDTH  write data to the controller.
- dram_req_read  out  1  read request to the controller.
- dram_req_write  out  1  write request to the controller.
- dram_data_out  in  DATA_WIDTH  read data from the controller.
- dram_data_out_valid  in  1  read done.
- dram_write_complete  in  1  write done.

Function
REQ-008 The FSM SHALL have three states: IDLE, BUSY and DONE.
REQ-009 In IDLE, the arbiter SHALL compute pending[i] = req_read[i] | req_write[i].
- If any port is pending, it SHALL grant the first pending port searching upward from last_grant+1, modulo NUM_PORTS (round-robin).
- On a grant it SHALL go to BUSY.
REQ-010 On a grant, the arbiter SHALL register the granted port's addr and data_in, plus the op type, into dram_addr, dram_data_in and the op register.
- If req_read and req_write are both high on the same port, the write SHALL be served and the read ignored for that grant.
REQ-011 dram_req_read or dram_req_write (per op) SHALL be high for every cycle in BUSY and low in every other state.
- The first asserted cycle is the cycle after the grant decision.
REQ-012 In BUSY, completion SHALL be recognised as follows:
- For a read, dram_data_out_valid SHALL capture dram_data_out into data_out.
- For a write, dram_write_complete SHALL count as completion.
- On completion the FSM SHALL go to DONE.
- A completion strobe that does not match the current op, or that arrives outside BUSY, SHALL be ignored.
REQ-013 In DONE, data_valid[g] (read) or write_complete[g] (write) SHALL be high for exactly one cycle.
- last_grant SHALL update to g.
- The FSM SHALL return to IDLE.
- The earliest next dram request SHALL be 2 cycles after DONE.
REQ-014 A master SHALL deassert its request in the cycle following its completion pulse; a request still held in IDLE is treated as a new request.
REQ-015 data_out SHALL hold its value until the next read completes; a write SHALL NOT change it.
REQ-016 A pending port SHALL be granted within NUM_PORTS-1 other transactions (starvation-free).
REQ-017 A request that drops during BUSY SHALL NOT abort the transaction; the completion pulse is still issued.

Reset
REQ-018 While rst is high, the block SHALL set:
- FSM = IDLE and last_grant = NUM_PORTS-1, so port 0 wins first.
- dram_req_read and dram_req_write = 0.
- data_valid, write_complete and timeout_err = 0.
- data_out, dram_addr and dram_data_in = 0.
REQ-019 Reset asserted in BUSY SHALL drop the DRAM request on the next edge, with no completion pulse.

Configuration
REQ-020 Macro ARB_TIMEOUT_EN SHALL control the watchdog.
- Defined: a counter SHALL count cycles spent in BUSY.
- When the count reaches TIMEOUT_CYCLES without completion, the arbiter SHALL deassert the DRAM request, pulse timeout_err[g] for one cycle instead of data_valid/write_complete, and go to DONE.
- Undefined: there is no counter, timeout_err is tied to 0, and BUSY waits indefinitely.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- Reset, then port 2 reads 0x000010 and the controller returns 0xDEADBEEF after 5 cycles: dram_req_read high on cycle 1, data_out = 0xDEADBEEF, data_valid = 0b0100 for 1 cycle.
- All 4 ports request reads at once and stay held: grant order 0,1,2,3,0, with exactly one dram request active at any time.
- Port 1 asserts req_read and req_write with data 0x12345678 at 0x000100: the write is issued, write_complete[1] pulses, and data_out is unchanged.
- rst pulsed while BUSY on port 3: dram_req_read low on the next edge, no data_valid, and the next grant goes to port 0.
- With ARB_TIMEOUT_EN and TIMEOUT_CYCLES = 8, the controller never responds: the request drops after 8 BUSY cycles, timeout_err[g] pulses, and the next port is granted.
